pipeline_ctrl: RTL and testbench

Parametrised pipeline stall/flush controller for the MIPS core. It generalises the fixed two-requester stall logic to STAGES pipeline stages, any of which may request a stall. It adds a counted multi-cycle hold for long-latency units such as the divider, an exception flush that overrides every stall, and saturating performance counters. It sits beside the pipeline registers and drives their stall and flush inputs.

---
 rtl/pipeline_ctrl_if.sv | 34 +++
 rtl/pipeline_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Bundles the stall/flush control signals shared between the pipeline
// requesters (master side) and the stall/flush controller (slave side).
interface pipeline_ctrl_if #(
  parameter int STAGES = 6,
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

  // Requests towards the controller
  logic [STAGES-1:0] stall_req;
  logic              hold_start;
  logic [SW-1:0]     hold_stage;
  logic [CNT_W-1:0]  hold_len;
  logic              flush_req;

  // Controls and status from the controller
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic              hold_busy;
  logic              hold_err;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;

  modport master (
    output stall_req, hold_start, hold_stage, hold_len, flush_req,
    input  stall, flush, hold_busy, hold_err, stall_cycles, flush_count
  );

  modport slave (
    input  stall_req, hold_start, hold_stage, hold_len, flush_req,
    output stall, flush, hold_busy, hold_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller. Any stage may request a stall; the
// highest requesting stage and everything upstream of it are frozen. A
// counted hold keeps one stage stalled for a programmed number of cycles,
// an exception flush overrides every stall, and two saturating counters
// record stalled cycles and flush cycles.
module pipeline_ctrl #(
  parameter int STAGES = 6,
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input logic            clk,
  input logic            reset,
  pipeline_ctrl_if.slave bus
);

  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [STAGES-1:0] FLUSH_MASK = {1'b0, {(STAGES-1){1'b1}}};
  localparam logic [STAGES-1:0] STG_ZERO   = {STAGES{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PERF_W-1:0] PERF_ONE   = {{(PERF_W-1){1'b0}}, 1'b1};
  localparam logic [PERF_W-1:0] PERF_MAX   = {PERF_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     held_q, held_d;
  logic              hold_err_q, hold_err_d;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_W-1:0] flush_count_q, flush_count_d;

  logic              hold_busy;
  logic              start_req;
  logic [STAGES-1:0] req_vec;
  logic [STAGES-1:0] stall_mask;
  logic [STAGES-1:0] stall_vec;
  logic [STAGES-1:0] flush_vec;
  logic              acc;

  assign hold_busy = (state_q == BUSY);

  // Collect every active requester: level requests, the running hold, and a
  // hold starting this cycle (it stalls in its own start cycle).
  always_comb begin
    start_req = bus.hold_start && (bus.hold_len != CNT_ZERO) && !hold_busy;
    req_vec   = STG_ZERO;
    for (int i = 0; i < STAGES; i++) begin
      req_vec[i] = bus.stall_req[i]
                 | (hold_busy && (held_q == SW'(i)))
                 | (start_req && (bus.hold_stage == SW'(i)));
    end
  end

  // Stall every stage at or below the highest requester: a running OR from
  // the top stage downwards yields exactly the thermometer mask for E.
  always_comb begin
    acc        = 1'b0;
    stall_mask = STG_ZERO;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc           = acc | req_vec[k];
      stall_mask[k] = acc;
    end
  end

  // Output priority: reset silences everything, then flush beats stall.
  always_comb begin
    stall_vec = STG_ZERO;
    flush_vec = STG_ZERO;
    if (!reset) begin
      stall_vec = STG_ZERO;
      flush_vec = STG_ZERO;
    end else if (bus.flush_req) begin
      stall_vec = STG_ZERO;
      flush_vec = FLUSH_MASK;
    end else begin
      stall_vec = stall_mask;
      flush_vec = STG_ZERO;
    end
  end

  // Hold FSM next state: load on a multi-cycle start, count down while busy,
  // abort on flush, and flag any start that arrives while already busy.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    held_d     = held_q;
    hold_err_d = hold_err_q;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (bus.hold_start && (bus.hold_len > CNT_ONE)) begin
          state_d = BUSY;
          cnt_d   = bus.hold_len - CNT_ONE;
          held_d  = bus.hold_stage;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus.hold_start) begin
          hold_err_d = 1'b1;
        end else begin
          hold_err_d = hold_err_q;
        end
        if (bus.flush_req) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = BUSY;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Hold FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      held_q     <= {SW{1'b0}};
      hold_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      hold_err_q <= hold_err_d;
    end
  end

  // Saturating performance counters: stop at all-ones instead of wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_vec[0] && (stall_cycles_q != PERF_MAX)) begin
      stall_cycles_d = stall_cycles_q + PERF_ONE;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (bus.flush_req && (flush_count_q != PERF_MAX)) begin
      flush_count_d = flush_count_q + PERF_ONE;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= {PERF_W{1'b0}};
      flush_count_q  <= {PERF_W{1'b0}};
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.stall        = stall_vec;
  assign bus.flush        = flush_vec;
  assign bus.hold_busy    = hold_busy;
  assign bus.hold_err     = hold_err_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each directed cycle pushes its
// hand-computed expectation, and a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.STAGES(6), .CNT_W(6), .PERF_W(4)) bus ();

  pipeline_ctrl #(.STAGES(6), .CNT_W(6), .PERF_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0] stall;
    logic [5:0] flush;
    logic       busy;
    logic       err;
    logic [3:0] sc;
    logic [3:0] fc;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", name, fld, act, req);
    end
  endtask

  // Monitor: compare outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.name, "stall",        32'(bus.stall),        32'(e.stall));
      chk(e.name, "flush",        32'(bus.flush),        32'(e.flush));
      chk(e.name, "hold_busy",    32'(bus.hold_busy),    32'(e.busy));
      chk(e.name, "hold_err",     32'(bus.hold_err),     32'(e.err));
      chk(e.name, "stall_cycles", 32'(bus.stall_cycles), 32'(e.sc));
      chk(e.name, "flush_count",  32'(bus.flush_count),  32'(e.fc));
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue the
  // expected outputs for that cycle.
  task automatic step(input logic rst, input logic [5:0] sr, input logic hs,
                      input logic [2:0] hst, input logic [5:0] hl, input logic fr,
                      input logic [5:0] es, input logic [5:0] ef, input logic eb,
                      input logic ee, input logic [3:0] esc, input logic [3:0] efc,
                      input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    bus.stall_req  = sr;
    bus.hold_start = hs;
    bus.hold_stage = hst;
    bus.hold_len   = hl;
    bus.flush_req  = fr;
    e.stall = es; e.flush = ef; e.busy = eb; e.err = ee;
    e.sc = esc; e.fc = efc; e.name = name;
    sb_q.push_back(e);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus.stall_req  = 6'b000000;
    bus.hold_start = 1'b0;
    bus.hold_stage = 3'd0;
    bus.hold_len   = 6'd0;
    bus.flush_req  = 1'b0;
    #2 reset = 1'b0;

    // Reset and plain stall requests
    step(1'b0, 6'b000000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 4'd0, 4'd0, "rst");
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 4'd0, 4'd0, "idle");
    step(1'b1, 6'b001000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b001111, 6'b000000, 1'b0, 1'b0, 4'd0, 4'd0, "req_e3");
    step(1'b1, 6'b000100, 1'b0, 3'd0, 6'd0, 1'b0, 6'b000111, 6'b000000, 1'b0, 1'b0, 4'd1, 4'd0, "req_e2");
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 4'd2, 4'd0, "req_none");

    // Five-cycle hold on EX with an overlapping request and a rejected restart
    step(1'b1, 6'b000000, 1'b1, 3'd3, 6'd5, 1'b0, 6'b001111, 6'b000000, 1'b0, 1'b0, 4'd2, 4'd0, "hold_t0");
    step(1'b1, 6'b010000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b011111, 6'b000000, 1'b1, 1'b0, 4'd3, 4'd0, "hold_t1_req4");
    step(1'b1, 6'b000000, 1'b1, 3'd1, 6'd3, 1'b0, 6'b001111, 6'b000000, 1'b1, 1'b0, 4'd4, 4'd0, "hold_t2_restart");
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b001111, 6'b000000, 1'b1, 1'b1, 4'd5, 4'd0, "hold_t3");
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b001111, 6'b000000, 1'b1, 1'b1, 4'd6, 4'd0, "hold_t4");
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b1, 4'd7, 4'd0, "hold_t5");

    // Flush aborting a hold, then flush discarding a same-cycle start
    step(1'b1, 6'b000000, 1'b1, 3'd3, 6'd5, 1'b0, 6'b001111, 6'b000000, 1'b0, 1'b1, 4'd7, 4'd0, "fl_t0");
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b001111, 6'b000000, 1'b1, 1'b1, 4'd8, 4'd0, "fl_t1");
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0, 1'b1, 6'b000000, 6'b011111, 1'b1, 1'b1, 4'd9, 4'd0, "fl_t2");
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b1, 4'd9, 4'd1, "fl_t3");
    step(1'b1, 6'b111111, 1'b1, 3'd2, 6'd4, 1'b1, 6'b000000, 6'b011111, 1'b0, 1'b1, 4'd9, 4'd1, "fl_start");
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b1, 4'd9, 4'd2, "fl_discard");

    // Hold length boundaries: zero is ignored, one stalls a single cycle
    step(1'b1, 6'b000000, 1'b1, 3'd4, 6'd0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b1, 4'd9, 4'd2, "len0");
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b1, 4'd9, 4'd2, "len0_after");
    step(1'b1, 6'b000000, 1'b1, 3'd2, 6'd1, 1'b0, 6'b000111, 6'b000000, 1'b0, 1'b1, 4'd9, 4'd2, "len1");
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b1, 4'd10, 4'd2, "len1_after");

    // Stall counter saturation at 4'hF after 2^4+3 stalled cycles
    step(1'b0, 6'b000000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 4'd0, 4'd0, "rst2");
    for (int k = 0; k < 19; k++) begin
      step(1'b1, 6'b000001, 1'b0, 3'd0, 6'd0, 1'b0, 6'b000001, 6'b000000, 1'b0, 1'b0,
           (k > 15) ? 4'd15 : 4'(k), 4'd0, "sat");
    end
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 4'd15, 4'd0, "sat_end");

    // Reset in the middle of a long hold
    step(1'b1, 6'b000000, 1'b1, 3'd3, 6'd10, 1'b0, 6'b001111, 6'b000000, 1'b0, 1'b0, 4'd15, 4'd0, "rh_t0");
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0,  1'b0, 6'b001111, 6'b000000, 1'b1, 1'b0, 4'd15, 4'd0, "rh_t1");
    step(1'b0, 6'b001000, 1'b0, 3'd0, 6'd0,  1'b1, 6'b000000, 6'b000000, 1'b0, 1'b0, 4'd0,  4'd0, "rh_rst");
    step(1'b0, 6'b001000, 1'b0, 3'd0, 6'd0,  1'b1, 6'b000000, 6'b000000, 1'b0, 1'b0, 4'd0,  4'd0, "rh_rst2");
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0,  1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 4'd0,  4'd0, "rh_release");
    step(1'b1, 6'b000000, 1'b0, 3'd0, 6'd0,  1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 4'd0,  4'd0, "rh_idle");

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain actual=%0d pending required=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
